mips_result_checker: RTL and testbench

Synthesizable end-of-program result checker for the MIPS pipeline. It holds up to MAX_CHECKS expected (register, value) pairs and counts cycles from start until the pipeline raises halt, or until a timeout expires. It then scans the register file through its debug read port, one entry per cycle, and reports pass/fail, the mismatch count, the first failing entry and the cycle count. It sits beside `mips` and connects to the `halt` output and a combinational register-bank read port, so on-board runs can self-check.

---
 rtl/mips_result_checker.sv | 138 +++++++++++++
 tb/tb_mips_result_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_result_checker.sv
// End-of-program result checker: counts run cycles until halt or timeout, then scans
// the register bank against a table of expected (register, value) pairs.
module mips_result_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int MAX_CHECKS     = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CYC_W          = 32,
    localparam int RA_W          = $clog2(NUM_REGS),
    localparam int IDX_W         = (MAX_CHECKS > 1) ? $clog2(MAX_CHECKS) : 1,
    localparam int FC_W          = $clog2(MAX_CHECKS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_exp_we,
    input  logic [IDX_W-1:0]      i_exp_idx,
    input  logic [RA_W-1:0]       i_exp_reg,
    input  logic [DATA_WIDTH-1:0] i_exp_val,
    input  logic                  i_clear,
    input  logic                  i_start,
    input  logic                  i_halt,
    output logic [RA_W-1:0]       o_rf_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [FC_W-1:0]       o_fail_count,
    output logic [IDX_W-1:0]      o_first_fail_idx,
    output logic [CYC_W-1:0]      o_cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SLOT    = IDX_W'(MAX_CHECKS - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [IDX_W-1:0]      scan_k;
    logic [MAX_CHECKS-1:0] slot_valid;
    logic [RA_W-1:0]       slot_reg [MAX_CHECKS];
    logic [DATA_WIDTH-1:0] slot_val [MAX_CHECKS];

    logic accept_cfg;
    logic mismatch;

    // Table edits are only safe while no scan can observe them.
    assign accept_cfg = (state == S_IDLE) || (state == S_DONE);
    assign mismatch   = slot_valid[scan_k] && (i_rf_data != slot_val[scan_k]);
    assign o_rf_addr  = (state == S_CHECK) ? slot_reg[scan_k] : '0;

    // NOTE: only the valid bits need reset; the fields behind an invalid slot are never compared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid <= '0;
        end else if (accept_cfg) begin
            if (i_clear) begin
                slot_valid <= '0;
            end else if (i_exp_we) begin
                slot_valid[i_exp_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_cfg && i_exp_we && !i_clear) begin
            slot_reg[i_exp_idx] <= i_exp_reg;
            slot_val[i_exp_idx] <= i_exp_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            scan_k           <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_timeout        <= 1'b0;
            o_fail_count     <= '0;
            o_first_fail_idx <= '0;
            o_cycle_count    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state            <= S_RUN;
                        scan_k           <= '0;
                        o_busy           <= 1'b1;
                        o_done           <= 1'b0;
                        o_pass           <= 1'b0;
                        o_timeout        <= 1'b0;
                        o_fail_count     <= '0;
                        o_first_fail_idx <= '0;
                        o_cycle_count    <= '0;
                    end
                end
                S_RUN: begin
                    // Halt has priority over a timeout falling on the same cycle.
                    if (i_halt) begin
                        state <= S_CHECK;
                    end else if (o_cycle_count == TIMEOUT_LAST) begin
                        state     <= S_CHECK;
                        o_timeout <= 1'b1;
                    end else begin
                        o_cycle_count <= o_cycle_count + CYC_W'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        o_fail_count <= o_fail_count + FC_W'(1);
                        if (o_fail_count == '0) begin
                            o_first_fail_idx <= scan_k;
                        end
                    end
                    if (scan_k == LAST_SLOT) begin
                        state  <= S_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_pass <= (o_fail_count == '0) && !mismatch && !o_timeout;
                    end else begin
                        scan_k <= scan_k + IDX_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_result_checker.sv
// Directed bench for mips_result_checker: R-type program results against a register-bank
// model, covering halt, timeout, halt/timeout collision, locked config and async reset.
module tb_mips_result_checker;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int MC  = 16;
    localparam int TO  = 50;
    localparam int RAW = 5;
    localparam int IW  = 4;
    localparam int FCW = 5;
    localparam int CW  = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           exp_we = 1'b0;
    logic [IW-1:0]  exp_idx = '0;
    logic [RAW-1:0] exp_reg = '0;
    logic [DW-1:0]  exp_val = '0;
    logic           clear = 1'b0;
    logic           start = 1'b0;
    logic           halt = 1'b0;
    logic [RAW-1:0] rf_addr;
    logic [DW-1:0]  rf_data;
    logic           busy, done, pass, timeout;
    logic [FCW-1:0] fail_count;
    logic [IW-1:0]  first_fail_idx;
    logic [CW-1:0]  cycle_count;

    logic [DW-1:0] rf_model [NR];
    assign rf_data = rf_model[rf_addr];

    int checks = 0;
    int passed = 0;

    int          prog_reg [14] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 15, 17, 18, 19};
    logic [31:0] prog_val [14] = '{32'd0, 32'd30, 32'd30, 32'hFFFF_FFE1, 32'd1, 32'd80, 32'd5,
                                   32'd30, 32'd10, 32'd1, 32'd2, 32'd160, 32'd5, 32'hFFFF_FFFF};

    mips_result_checker #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .MAX_CHECKS(MC), .TIMEOUT_CYCLES(TO), .CYC_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .i_exp_we(exp_we), .i_exp_idx(exp_idx), .i_exp_reg(exp_reg), .i_exp_val(exp_val),
        .i_clear(clear), .i_start(start), .i_halt(halt),
        .o_rf_addr(rf_addr), .i_rf_data(rf_data),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(timeout),
        .o_fail_count(fail_count), .o_first_fail_idx(first_fail_idx), .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_matching();
        for (int i = 0; i < NR; i++) rf_model[i] = '0;
        for (int i = 0; i < 14; i++) rf_model[prog_reg[i]] = prog_val[i];
    endtask

    task automatic load_program();
        for (int i = 0; i < 14; i++) begin
            exp_we  = 1'b1;
            exp_idx = IW'(i);
            exp_reg = RAW'(prog_reg[i]);
            exp_val = prog_val[i];
            tick();
        end
        exp_we = 1'b0;
    endtask

    // Leaves the bench at the negedge inside RUN cycle 0.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges until o_done; halt is dropped after the first edge, start pulsed on edge 'poke'.
    task automatic wait_done(input int poke, output int lat, output logic [RAW-1:0] first_addr);
        lat = 0;
        first_addr = '0;
        do begin
            tick();
            lat++;
            halt = 1'b0;
            start = (lat == poke);
            if (lat == 1) first_addr = rf_addr;
        end while (!done && lat < 200);
        start = 1'b0;
    endtask

    initial begin
        int lat;
        logic [RAW-1:0] a0;

        model_matching();
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_rf_addr", rf_addr, 0);
        reset = 1'b1;
        tick();

        // Scenario 1: matching bank, halt on RUN cycle 40.
        load_program();
        start_run();
        check("s1_busy", busy, 1);
        check("s1_cycle0", cycle_count, 0);
        repeat (40) tick();
        halt = 1'b1;
        wait_done(0, lat, a0);
        check("s1_latency", lat, 17);
        check("s1_first_addr", a0, 3);
        check("s1_pass", pass, 1);
        check("s1_fail_count", fail_count, 0);
        check("s1_cycle_count", cycle_count, 40);
        check("s1_busy_done", busy, 0);

        // Scenario 2: $4 reads 0 (slot 1), $9 reads 4 (slot 6).
        rf_model[4] = 32'd0;
        rf_model[9] = 32'd4;
        start_run();
        repeat (40) tick();
        halt = 1'b1;
        wait_done(0, lat, a0);
        check("s2_latency", lat, 17);
        check("s2_pass", pass, 0);
        check("s2_fail_count", fail_count, 2);
        check("s2_first_fail", first_fail_idx, 1);

        // Scenario 3: no halt, timeout after RUN cycle 49.
        model_matching();
        start_run();
        wait_done(0, lat, a0);
        check("s3_latency", lat, 49 + 17);
        check("s3_timeout", timeout, 1);
        check("s3_cycle_count", cycle_count, 49);
        check("s3_pass", pass, 0);

        // Scenario 4: halt on the cycle the timeout would fire.
        start_run();
        check("s4_timeout_cleared", timeout, 0);
        repeat (49) tick();
        halt = 1'b1;
        wait_done(0, lat, a0);
        check("s4_latency", lat, 17);
        check("s4_timeout", timeout, 0);
        check("s4_pass", pass, 1);
        check("s4_cycle_count", cycle_count, 49);

        // Scenario 5: config writes during RUN and a start during CHECK are ignored.
        start_run();
        exp_we  = 1'b1;
        exp_idx = 4'd1;
        exp_reg = 5'd4;
        exp_val = 32'd99;
        tick();
        exp_we = 1'b0;
        clear  = 1'b1;
        tick();
        clear = 1'b0;
        repeat (38) tick();
        halt = 1'b1;
        wait_done(3, lat, a0);
        check("s5_latency", lat, 17);
        check("s5_pass", pass, 1);
        check("s5_fail_count", fail_count, 0);
        check("s5_cycle_count", cycle_count, 40);

        // Scenario 6: asynchronous reset mid-CHECK after a mismatch has been counted.
        rf_model[4] = 32'd0;
        start_run();
        repeat (5) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        repeat (4) tick();
        check("s6_busy_before", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("s6_rst_busy", busy, 0);
        check("s6_rst_done", done, 0);
        check("s6_rst_pass", pass, 0);
        check("s6_rst_timeout", timeout, 0);
        check("s6_rst_fail_count", fail_count, 0);
        check("s6_rst_first_fail", first_fail_idx, 0);
        check("s6_rst_cycle_count", cycle_count, 0);
        check("s6_rst_rf_addr", rf_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        start_run();
        repeat (3) tick();
        halt = 1'b1;
        wait_done(0, lat, a0);
        check("s6_latency", lat, 17);
        check("s6_pass", pass, 1);
        check("s6_fail_count", fail_count, 0);
        check("s6_first_fail", first_fail_idx, 0);
        check("s6_cycle_count", cycle_count, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
